lector_registros: RTL and testbench
===================================

Name: lector_registros

Overview:
- Parallel-in, serial-out reader for the team's DEPTH-deep register chain.
- Captures a full snapshot of the chain's parallel output in one cycle, then streams the words out one per valid/ready handshake.
- Output order is oldest word first: highest occupied index down to index 0, which preserves push order.
- Sits downstream of the shift-register bank and feeds any consumer that uses a valid/ready interface.

Parameters:
WIDTH, 32, bit width of each word
DEPTH, 4, number of words in a snapshot (>=1)
LW, $clog2(DEPTH+1), width of len_i / remaining_o (derived, not overridable)

Ports:
clk_i  input  1  clock; all state changes on the rising edge
rst_i  input  1  synchronous active-high reset
load_i  input  1  request to capture data_i; honoured only when load_rdy_o=1
len_i  input  LW  number of valid words in snapshot (indices len_i-1..0)
data_i  input  [DEPTH-1:0][WIDTH-1:0]  parallel snapshot, same packing as the register chain output
load_rdy_o  output  1  high in IDLE; block accepts load_i
data_o  output  WIDTH  current serial word
valid_o  output  1  data_o is valid
ready_i  input  1  consumer accepts data_o this cycle
last_o  output  1  high with valid_o on the final word of the snapshot
remaining_o  output  LW  words not yet accepted, including the current one
done_o  output  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE. Outputs: load_rdy_o=1, valid_o=0, last_o=0, done_o=0, remaining_o=0, data_o=0. Internal snapshot cleared to 0.
- Reset overrides everything, including mid-stream operation. A partially sent snapshot is discarded with no done_o.

States: IDLE, SEND.

IDLE:
- load_rdy_o=1, valid_o=0.
- load_i=1 with len_i>=1: capture data_i into the internal snapshot, set idx=min(len_i,DEPTH)-1, set remaining=min(len_i,DEPTH), go to SEND.
- len_i>DEPTH is clamped to DEPTH.
- load_i=1 with len_i=0 is ignored: stay IDLE, no outputs change.

SEND:
- load_rdy_o=0, valid_o=1, data_o=snapshot[idx], remaining_o=remaining, last_o=(idx==0).
- Transfer occurs when valid_o & ready_i at a clock edge.
- Transfer with idx>0: idx-=1, remaining-=1.
- Transfer with idx==0: go to IDLE, remaining=0, done_o=1 for exactly the next cycle.
- No transfer: data_o, idx and remaining hold (AXI-style stability; valid_o never drops without a transfer).
- load_i is ignored in SEND. Changes on data_i have no effect after capture.

Timing:
- Load accepted at edge N: valid_o=1 from cycle N+1 with the first word.
- With ready_i held high, len words need len consecutive cycles. IDLE (done_o=1, load_rdy_o=1) follows on the next cycle.
- A new load_i in the done_o cycle is accepted. Back-to-back snapshot gap is one cycle.
- ready_i while valid_o=0 has no effect.
- data_o is a registered output: no combinational path from ready_i or load_i to any output.

Test Plan:
- Basic stream: reset, load_i=1, len_i=4, data_i={32'hD,32'hC,32'hB,32'hA} (index 3..0), ready_i=1 -> data_o D,C,B,A on cycles N+1..N+4; last_o only with A; remaining_o 4,3,2,1; done_o=1 at N+5, load_rdy_o=1.
- Backpressure: same load, ready_i pattern 1,0,0,1,1,0,1 -> each word held stable while ready_i=0; exactly 4 transfers in order D,C,B,A; done_o after the 7th cycle.
- Partial and clamped lengths: len_i=2 -> words at index 1 then 0 only, last_o on the second. len_i=7 (LW=3) -> treated as 4. len_i=0 -> no state change, valid_o stays 0.
- Load ignored while busy: during SEND assert load_i with new data_i={32'h1,32'h2,32'h3,32'h4} -> output stream unchanged; the new data never appears.
- Reset mid-stream: after 2 of 4 words, rst_i=1 for one edge -> next cycle valid_o=0, remaining_o=0, load_rdy_o=1, done_o=0; a fresh load then streams correctly.
- Back-to-back loads: second load asserted in the done_o cycle -> first word of the second snapshot appears on the following cycle; no duplicated or dropped words.

Source files
------------

// File: rtl/lector_registros.sv
// Parallel-in, serial-out reader for the register chain.
// Captures a whole snapshot of the chain in one cycle, then hands the words
// out oldest first (highest occupied index down to 0) over valid/ready.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a load with a non-zero length; load_rdy_o high
// SEND  | presenting snapshot[idx] with valid_o high until it is taken
module lector_registros #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         load_i,
    input  logic [LW-1:0]                len_i,
    input  logic [DEPTH-1:0][WIDTH-1:0]  data_i,
    output logic                         load_rdy_o,
    output logic [WIDTH-1:0]             data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         last_o,
    output logic [LW-1:0]                remaining_o,
    output logic                         done_o
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                        state, state_nxt;
    logic [DEPTH-1:0][WIDTH-1:0]   snap, snap_nxt;
    logic [IW-1:0]                 idx, idx_nxt;
    logic [LW-1:0]                 remaining, remaining_nxt;
    logic [WIDTH-1:0]              data_q, data_nxt;
    logic                          done_q, done_nxt;

    logic [LW-1:0]                 len_eff;
    logic [IW-1:0]                 idx_first;

    // Clamp the requested length to the chain depth and derive the first index.
    always_comb begin
        len_eff   = (len_i > LW'(DEPTH)) ? LW'(DEPTH) : len_i;
        idx_first = IW'(len_eff - LW'(1));
    end

    // State and datapath registers; reset discards any partial snapshot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            snap      <= '0;
            idx       <= '0;
            remaining <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            snap      <= snap_nxt;
            idx       <= idx_nxt;
            remaining <= remaining_nxt;
            data_q    <= data_nxt;
            done_q    <= done_nxt;
        end
    end

    // Next-state logic; data_o is preloaded with the word to show next cycle
    // so no output depends combinationally on ready_i or load_i.
    always_comb begin
        state_nxt     = state;
        snap_nxt      = snap;
        idx_nxt       = idx;
        remaining_nxt = remaining;
        data_nxt      = data_q;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (load_i && (len_i != '0)) begin
                    snap_nxt      = data_i;
                    idx_nxt       = idx_first;
                    remaining_nxt = len_eff;
                    data_nxt      = data_i[idx_first];
                    state_nxt     = SEND;
                end
            end
            SEND: begin
                if (ready_i) begin
                    if (idx == '0) begin
                        remaining_nxt = '0;
                        done_nxt      = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        idx_nxt       = idx - IW'(1);
                        remaining_nxt = remaining - LW'(1);
                        data_nxt      = snap[idx - IW'(1)];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        load_rdy_o  = (state == IDLE);
        valid_o     = (state == SEND);
        last_o      = (state == SEND) && (idx == '0);
        data_o      = data_q;
        remaining_o = remaining;
        done_o      = done_q;
    end

endmodule

// File: tb/tb_lector_registros.sv
// Scoreboard bench for lector_registros: stimulus pushes hand-computed words,
// a monitor on the falling edge compares whatever the DUT presents.
module tb_lector_registros;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             l;
        logic [LW-1:0]    r;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        rst_i = 1'b1;
    logic                        load_i = 1'b0;
    logic                        ready_i = 1'b0;
    logic [LW-1:0]               len_i = '0;
    logic [DEPTH-1:0][WIDTH-1:0] data_i = '0;
    logic                        load_rdy_o, valid_o, last_o, done_o;
    logic [WIDTH-1:0]            data_o;
    logic [LW-1:0]               remaining_o;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    lector_registros #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .load_i      (load_i),
        .len_i       (len_i),
        .data_i      (data_i),
        .load_rdy_o  (load_rdy_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .remaining_o (remaining_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic l, input logic [LW-1:0] r);
        exp_t e;
        e.d = d;
        e.l = l;
        e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i  = 1'b1;
        load_i = 1'b0;
        exp_q.delete();
        step();
        rst_i = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, valid_o, 1'b0);
        chk({tag, "_load_rdy"}, load_rdy_o, 1'b1);
        chk({tag, "_remaining"}, remaining_o, 0);
        chk({tag, "_last"}, last_o, 1'b0);
    endtask

    task automatic load(input logic [LW-1:0] len, input logic [DEPTH-1:0][WIDTH-1:0] d);
        int n;
        n = 0;
        while (!load_rdy_o && n < 100) begin
            step();
            n++;
        end
        chk("load_rdy_before_load", load_rdy_o, 1'b1);
        load_i = 1'b1;
        len_i  = len;
        data_i = d;
        step();
        load_i = 1'b0;
        chk("valid_after_load", valid_o, (len != '0));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid_o) && n < 100) begin
            step();
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_valid_low", valid_o, 1'b0);
    endtask

    // Monitor: compares every presented word; pops on a handshake; tracks done.
    initial begin
        logic pend_done;
        pend_done = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && !rst_i) begin
                chk("mon_done", done_o, pend_done);
                pend_done = 1'b0;
                if (valid_o) begin
                    if (exp_q.size() == 0) begin
                        chk("mon_unexpected_word", data_o, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        chk("mon_data", data_o, exp_q[0].d);
                        chk("mon_last", last_o, exp_q[0].l);
                        chk("mon_remaining", remaining_o, exp_q[0].r);
                        if (ready_i) begin
                            pend_done = last_o;
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end else begin
                pend_done = 1'b0;
            end
        end
    end

    initial begin
        logic [DEPTH-1:0][WIDTH-1:0] abcd;
        logic [DEPTH-1:0][WIDTH-1:0] other;
        logic [DEPTH-1:0][WIDTH-1:0] second;
        logic [6:0] pat;
        int n;
        abcd   = {32'hD, 32'hC, 32'hB, 32'hA};
        other  = {32'h1, 32'h2, 32'h3, 32'h4};
        second = {32'h44, 32'h33, 32'h22, 32'h11};
        pat    = 7'b1011001;

        // Reset state
        do_reset();
        mon_en = 1'b1;
        check_idle("reset");
        chk("reset_data", data_o, 0);
        chk("reset_done", done_o, 1'b0);

        // Basic stream, ready held high
        ready_i = 1'b1;
        push(32'hD, 1'b0, 3'd4);
        push(32'hC, 1'b0, 3'd3);
        push(32'hB, 1'b0, 3'd2);
        push(32'hA, 1'b1, 3'd1);
        load(3'd4, abcd);
        chk("basic_first_word", data_o, 32'hD);
        chk("basic_load_rdy_busy", load_rdy_o, 1'b0);
        repeat (4) step();
        chk("basic_done", done_o, 1'b1);
        check_idle("basic_after");

        // Backpressure: pattern 1,0,0,1,1,0,1 (LSB first)
        ready_i = 1'b0;
        push(32'hD, 1'b0, 3'd4);
        push(32'hC, 1'b0, 3'd3);
        push(32'hB, 1'b0, 3'd2);
        push(32'hA, 1'b1, 3'd1);
        load(3'd4, abcd);
        for (int i = 0; i < 7; i++) begin
            ready_i = pat[i];
            step();
        end
        chk("bp_done", done_o, 1'b1);
        chk("bp_queue_empty", exp_q.size(), 0);
        ready_i = 1'b1;

        // Partial length
        push(32'hB, 1'b0, 3'd2);
        push(32'hA, 1'b1, 3'd1);
        load(3'd2, abcd);
        wait_drain();

        // Clamped length 7 -> 4
        push(32'hD, 1'b0, 3'd4);
        push(32'hC, 1'b0, 3'd3);
        push(32'hB, 1'b0, 3'd2);
        push(32'hA, 1'b1, 3'd1);
        load(3'd7, abcd);
        wait_drain();

        // Zero length is ignored
        load(3'd0, abcd);
        step();
        check_idle("len0");

        // Load ignored while busy
        ready_i = 1'b0;
        push(32'hD, 1'b0, 3'd4);
        push(32'hC, 1'b0, 3'd3);
        push(32'hB, 1'b0, 3'd2);
        push(32'hA, 1'b1, 3'd1);
        load(3'd4, abcd);
        load_i = 1'b1;
        len_i  = 3'd4;
        data_i = other;
        repeat (3) step();
        chk("busy_load_rdy", load_rdy_o, 1'b0);
        chk("busy_data_held", data_o, 32'hD);
        ready_i = 1'b1;
        step();
        step();
        load_i = 1'b0;
        wait_drain();

        // Reset mid-stream after two words
        push(32'hD, 1'b0, 3'd4);
        push(32'hC, 1'b0, 3'd3);
        push(32'hB, 1'b0, 3'd2);
        push(32'hA, 1'b1, 3'd1);
        load(3'd4, abcd);
        step();
        step();
        do_reset();
        check_idle("midrst");
        chk("midrst_done", done_o, 1'b0);
        push(32'hC, 1'b0, 3'd3);
        push(32'hB, 1'b0, 3'd2);
        push(32'hA, 1'b1, 3'd1);
        load(3'd3, abcd);
        wait_drain();

        // Back-to-back: second load issued in the done cycle
        push(32'hD, 1'b0, 3'd4);
        push(32'hC, 1'b0, 3'd3);
        push(32'hB, 1'b0, 3'd2);
        push(32'hA, 1'b1, 3'd1);
        push(32'h33, 1'b0, 3'd3);
        push(32'h22, 1'b0, 3'd2);
        push(32'h11, 1'b1, 3'd1);
        load(3'd4, abcd);
        n = 0;
        while (!done_o && n < 20) begin
            step();
            n++;
        end
        chk("b2b_done_seen", done_o, 1'b1);
        chk("b2b_load_rdy_in_done", load_rdy_o, 1'b1);
        load(3'd3, second);
        chk("b2b_first_word", data_o, 32'h33);
        wait_drain();

        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
